// File: rtl/gen_rate_ctrl.sv
// Run/pause/step and speed controller for the generation timebase; drives counter_1s freq
// and issues one req/ack generation update per tick. Optional macro: OVERRUN_CNT_EN.
module gen_rate_ctrl #(
    parameter int FREQ_STEP   = 50,
    parameter int NUM_LEVELS  = 8,
    parameter int RESET_LEVEL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_faster,
    input  logic        btn_slower,
    input  logic        btn_pause,
    input  logic        btn_step,
    input  logic        tick_in,
    input  logic        gen_ack,
    output logic [29:0] freq,
    output logic        gen_req,
    output logic        running,
    output logic [2:0]  level,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [1:0] {S_PAUSE, S_RUN, S_BUSY} state_t;

    localparam logic [2:0]  MAX_LEVEL = 3'(NUM_LEVELS - 1);
    localparam logic [2:0]  RST_LEVEL = 3'(RESET_LEVEL);
    localparam logic [29:0] RST_FREQ  = 30'(FREQ_STEP * (RESET_LEVEL + 1));

    // Bit order of the edge-detect vectors: {tick, step, pause, slower, faster}
    logic [4:0]  in_d, in_q;
    logic [4:0]  ev_d, ev_q;
    state_t      state_d, state_q;
    logic        running_d, running_q;
    logic        gen_req_d, gen_req_q;
    logic [2:0]  level_d, level_q;
    logic [29:0] freq_d, freq_q;

    logic ev_faster, ev_slower, ev_pause, ev_step, ev_tick;

    assign in_d = {tick_in, btn_step, btn_pause, btn_slower, btn_faster};
    assign ev_d = in_d & ~in_q;

    assign ev_faster = ev_q[0];
    assign ev_slower = ev_q[1];
    assign ev_pause  = ev_q[2];
    assign ev_step   = ev_q[3];
    assign ev_tick   = ev_q[4];

    always_comb begin
        level_d = level_q;
        if (ev_faster && !ev_slower && level_q != MAX_LEVEL) begin
            level_d = level_q + 3'd1;
        end else if (ev_slower && !ev_faster && level_q != 3'd0) begin
            level_d = level_q - 3'd1;
        end
        freq_d = 30'(FREQ_STEP) * (30'(level_d) + 30'd1);
    end

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        case (state_q)
            S_PAUSE: begin
                if (ev_pause) begin
                    running_d = 1'b1;
                    state_d   = S_RUN;
                end else if (ev_step) begin
                    state_d = S_BUSY;
                end
            end
            S_RUN: begin
                // A pause arriving with a tick wins; the tick is simply lost.
                if (ev_pause) begin
                    running_d = 1'b0;
                    state_d   = S_PAUSE;
                end else if (ev_tick) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ev_pause) begin
                    running_d = ~running_q;
                end
                if (gen_ack) begin
                    state_d = running_d ? S_RUN : S_PAUSE;
                end
            end
            default: begin
                state_d   = S_PAUSE;
                running_d = 1'b0;
            end
        endcase
        gen_req_d = (state_d == S_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= '0;
            ev_q      <= '0;
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
            gen_req_q <= 1'b0;
            level_q   <= RST_LEVEL;
            freq_q    <= RST_FREQ;
        end else begin
            in_q      <= in_d;
            ev_q      <= ev_d;
            state_q   <= state_d;
            running_q <= running_d;
            gen_req_q <= gen_req_d;
            level_q   <= level_d;
            freq_q    <= freq_d;
        end
    end

`ifdef OVERRUN_CNT_EN
    logic [7:0] overrun_d, overrun_q;
    logic       ovr_tick;

    assign ovr_tick = (state_q == S_BUSY) && ev_tick;

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_tick && overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_cnt = overrun_q;
`else
    assign overrun_cnt = '0;
`endif

    assign freq    = freq_q;
    assign gen_req = gen_req_q;
    assign running = running_q;
    assign level   = level_q;

endmodule

// File: tb/tb_gen_rate_ctrl.sv
// Scoreboard bench for gen_rate_ctrl: a behavioural model pushes the expected output vector
// for every stimulus step and each scenario task pops and compares it once the DUT has reacted.
module tb_gen_rate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_faster = 1'b0, btn_slower = 1'b0, btn_pause = 1'b0, btn_step = 1'b0;
    logic        tick_in = 1'b0, gen_ack = 1'b0;
    logic [29:0] freq;
    logic        gen_req, running;
    logic [2:0]  level;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] F = 5'b00001, S = 5'b00010, P = 5'b00100, ST = 5'b01000, T = 5'b10000;
    localparam int M_PAUSE = 0, M_RUN = 1, M_BUSY = 2;

    typedef struct packed {
        logic [4:0] btn;
        logic       ack;
        logic [3:0] idle;
    } op_t;

    typedef logic [42:0] vec_t;  // {running, gen_req, level, freq, overrun_cnt}

    vec_t sb[$];
    int   m_state, m_level, m_ovr;
    bit   m_running;

    gen_rate_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_faster (btn_faster),
        .btn_slower (btn_slower),
        .btn_pause  (btn_pause),
        .btn_step   (btn_step),
        .tick_in    (tick_in),
        .gen_ack    (gen_ack),
        .freq       (freq),
        .gen_req    (gen_req),
        .running    (running),
        .level      (level),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic op_t mk(input logic [4:0] btn, input logic ack, input int idle);
        op_t o;
        o.btn  = btn;
        o.ack  = ack;
        o.idle = 4'(idle);
        return o;
    endfunction

    function automatic void model_reset();
        m_state   = M_PAUSE;
        m_level   = 1;
        m_ovr     = 0;
        m_running = 1'b0;
    endfunction

    function automatic vec_t model_vec();
        return {m_running, (m_state == M_BUSY), 3'(m_level), 30'(50 * (m_level + 1)), 8'(m_ovr)};
    endfunction

    function automatic vec_t dut_vec();
        return {running, gen_req, level, freq, overrun_cnt};
    endfunction

    // Expected effect of one op: ack lands on the first edge, button/tick events on the second.
    function automatic void model_apply(input op_t op);
        bit f, s, p, st, t;
        {t, st, p, s, f} = op.btn;
        if (op.ack && m_state == M_BUSY) m_state = m_running ? M_RUN : M_PAUSE;
        if (f && !s && m_level < 7) m_level++;
        else if (s && !f && m_level > 0) m_level--;
        case (m_state)
            M_PAUSE: if (p) begin m_running = 1'b1; m_state = M_RUN; end
                     else if (st) m_state = M_BUSY;
            M_RUN:   if (p) begin m_running = 1'b0; m_state = M_PAUSE; end
                     else if (t) m_state = M_BUSY;
            default: begin
                if (p) m_running = !m_running;
`ifdef OVERRUN_CNT_EN
                if (t && m_ovr < 255) m_ovr++;
`endif
            end
        endcase
    endfunction

    task automatic run_op(input op_t op);
        {tick_in, btn_step, btn_pause, btn_slower, btn_faster} = op.btn;
        gen_ack = op.ack;
        @(posedge clk); #1;
        {tick_in, btn_step, btn_pause, btn_slower, btn_faster} = '0;
        gen_ack = 1'b0;
        @(posedge clk); #1;
        repeat (int'(op.idle)) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        op_t  ops[$];
        vec_t exp_v, obs;
        rst_n = 1'b0;
        model_reset();
        sb.push_back(model_vec());
        repeat (2) @(posedge clk);
        #1;
        exp_v = sb.pop_front(); obs = dut_vec(); checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", obs, exp_v);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        ops = {mk(T, 0, 2), mk(T, 0, 0)};
        foreach (ops[i]) begin
            model_apply(ops[i]);
            sb.push_back(model_vec());
            run_op(ops[i]);
            exp_v = sb.pop_front(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_tick[%0d]: got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_speed();
        op_t  ops[$];
        vec_t exp_v, obs;
        for (int i = 0; i < 10; i++) ops.push_back(mk(F, 0, 0));
        for (int i = 0; i < 10; i++) ops.push_back(mk(S, 0, 0));
        ops.push_back(mk(F | S, 0, 0));
        ops.push_back(mk(F, 0, 0));
        ops.push_back(mk(F | S, 0, 1));
        foreach (ops[i]) begin
            model_apply(ops[i]);
            sb.push_back(model_vec());
            run_op(ops[i]);
            exp_v = sb.pop_front(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL speed[%0d]: got lvl=%0d freq=%0d (vec %h) required vec %h",
                         i, level, freq, obs, exp_v);
            end
        end
    endtask

    task automatic test_run();
        op_t  ops[$];
        vec_t exp_v, obs;
        ops = {mk(P, 0, 0), mk(T, 0, 0), mk(0, 0, 3), mk(0, 1, 0), mk(0, 1, 1),
               mk(T, 0, 1), mk(F, 0, 0), mk(0, 1, 0), mk(P | T, 0, 2), mk(P | ST, 0, 2),
               mk(P, 0, 0)};
        foreach (ops[i]) begin
            model_apply(ops[i]);
            sb.push_back(model_vec());
            run_op(ops[i]);
            exp_v = sb.pop_front(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run[%0d]: got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_step();
        op_t  ops[$];
        vec_t exp_v, obs;
        ops = {mk(ST, 0, 2), mk(ST, 0, 0), mk(0, 1, 2), mk(P, 0, 0), mk(ST, 0, 2), mk(ST, 0, 2)};
        foreach (ops[i]) begin
            model_apply(ops[i]);
            sb.push_back(model_vec());
            run_op(ops[i]);
            exp_v = sb.pop_front(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL step[%0d]: got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_overrun();
        op_t  ops[$];
        vec_t exp_v, obs;
        ops = {mk(T, 0, 0), mk(T, 0, 0), mk(T, 0, 0), mk(T, 0, 1), mk(0, 1, 0),
               mk(T, 0, 0), mk(P, 0, 0), mk(0, 1, 0), mk(T, 0, 1)};
        foreach (ops[i]) begin
            model_apply(ops[i]);
            sb.push_back(model_vec());
            run_op(ops[i]);
            exp_v = sb.pop_front(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL overrun[%0d]: got req=%0b ovr=%0d (vec %h) required vec %h",
                         i, gen_req, overrun_cnt, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t exp_v, obs;
        op_t  op;
        op = mk(ST, 0, 1);
        model_apply(op);
        sb.push_back(model_vec());
        run_op(op);
        exp_v = sb.pop_front(); obs = dut_vec(); checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL midreset_setup: got %h required %h", obs, exp_v);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        sb.push_back(model_vec());
        #1;
        exp_v = sb.pop_front(); obs = dut_vec(); checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL midreset_async: got req=%0b (vec %h) required vec %h", gen_req, obs, exp_v);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        op = mk(T, 0, 1);
        model_apply(op);
        sb.push_back(model_vec());
        run_op(op);
        exp_v = sb.pop_front(); obs = dut_vec(); checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL midreset_paused: got %h required %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_speed();
        test_run();
        test_step();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_rate_ctrl.md
Name: gen_rate_ctrl

Overview:
- Run/pause/step and speed controller for the generation timebase.
- Selects the 30-bit `freq` word driven into `counter_1s` from a saturating speed level.
- Watches the returned `clk_1s` tick and issues one generation-update request per tick to the grid updater over a req/ack handshake.
- Sits between the debounced front-panel buttons, `counter_1s`, and the life-grid engine.

Parameters:
- FREQ_STEP, 50: freq increment per speed level.
- NUM_LEVELS, 8: number of speed levels, 0..NUM_LEVELS-1.
- RESET_LEVEL, 1: speed level after reset (freq = 100).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_faster  in  1  debounced level; rising edge raises speed level.
- btn_slower  in  1  debounced level; rising edge lowers speed level.
- btn_pause  in  1  debounced level; rising edge toggles run/pause.
- btn_step  in  1  debounced level; rising edge requests a single generation while paused.
- tick_in  in  1  `clk_1s` from `counter_1s`, synchronous to clk.
- gen_ack  in  1  grid engine acknowledges gen_req, 1-cycle pulse.
- freq  out  30  rate word to `counter_1s`.
- gen_req  out  1  generation-update request, held until acked.
- running  out  1  1 = run mode, 0 = paused.
- level  out  3  current speed level.
- overrun_cnt  out  8  dropped-tick count (see Optional Feature).

Behaviour:
- Reset values (async, all outputs):
  - level = RESET_LEVEL; freq = FREQ_STEP*(RESET_LEVEL+1) = 100.
  - running = 0, gen_req = 0, overrun_cnt = 0.
  - FSM = S_PAUSE; all edge-detect history registers = 0.
- Edge detection on every button and on tick_in: event = in & ~in_q, where in_q is the input registered on clk.
- Event reaction: the registered event acts on the next clock edge, so outputs change 1 cycle after the edge where the input is first sampled high.
- Speed:
  - faster event: level = min(level+1, NUM_LEVELS-1).
  - slower event: level = max(level-1, 0).
  - faster and slower in the same cycle: no change.
  - freq is registered: freq = FREQ_STEP*(level+1), updated in the same cycle as level, computed in 30 bits with no overflow at the defaults.
  - Speed changes are accepted in every state.
- FSM states S_PAUSE, S_RUN, S_BUSY; running flag held separately.
  - S_PAUSE, pause event: running <= 1, go to S_RUN.
  - S_PAUSE, step event (with no pause event): go to S_BUSY, running stays 0.
  - S_PAUSE, pause and step events in the same cycle: the pause event wins; step is ignored.
  - S_PAUSE: tick events are ignored (no overrun count).
  - S_RUN, tick event: go to S_BUSY.
  - S_RUN, pause event: running <= 0, go to S_PAUSE. If a tick event occurs in the same cycle, the pause event wins and the tick is dropped without counting.
  - S_RUN: step events are ignored.
  - S_BUSY: gen_req = 1 (registered, asserted the cycle after entry).
  - S_BUSY, gen_ack high: gen_req drops the next cycle; go to S_RUN if running = 1, else S_PAUSE.
  - S_BUSY, pause event: toggles running but does not abort the handshake; the exit target uses the updated flag.
  - S_BUSY, tick event: the tick is dropped (overrun).
  - S_BUSY, step event: ignored.
  - gen_ack outside S_BUSY: ignored.
- Handshake invariant: at most one outstanding request; gen_req never deasserts without gen_ack or reset.
- Reset mid-handshake: gen_req falls immediately (async), FSM returns to S_PAUSE.

Optional Feature:
- OVERRUN_CNT_EN defined:
  - overrun_cnt increments on each tick event seen in S_BUSY, saturating at 255.
  - Cleared only by reset.
- OVERRUN_CNT_EN undefined:
  - overrun_cnt is tied to 0 and no counter logic is built.
  - Port list is unchanged.

Test Plan:
- Reset, no stimulus -> freq = 100, level = 1, running = 0, gen_req = 0; pulse tick_in -> gen_req stays 0.
- 10 faster events from reset -> level = 7, freq = 400 saturated; then 10 slower events -> level = 0, freq = 50; faster and slower pulsed together -> freq unchanged.
- Pause event, then tick_in pulse -> gen_req high 2 cycles after tick rises, held until gen_ack; returns to S_RUN, running = 1.
- Paused, step event -> exactly one gen_req/ack cycle; running remains 0; step events while running produce no gen_req.
- Running, gen_ack withheld, 3 extra tick pulses -> single gen_req held; overrun_cnt = 3 with OVERRUN_CNT_EN, 0 without; after ack, next tick produces a new request.
- gen_req high, rst_n driven low between clock edges -> gen_req = 0 immediately; after release, freq = 100 and FSM in S_PAUSE.
